// File: rtl/circular_peek_fifo.sv
// circular_peek_fifo
//   Single-clock circular FIFO. Writes use a valid/ready handshake. The read side
//   shows a window of the oldest PEEK_DEPTH entries at once. Each cycle, pop_cnt
//   retires 0..PEEK_DEPTH of those entries.
//
//   Depth: BUFFER_SIZE is rounded up to a power of two DEPTH (minimum 2).
//   Pointers: both pointers are AW+1 bits wide. The extra MSB separates full
//   from empty after the pointers wrap.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   wr_valid/wr_data  write request and data
//   wr_ready          !full; depends only on registered state
//   rd_data           peek window; slot k = entry at rd_ptr+k, or 0 when that slot is not valid
//   rd_valid          bit k set when k < occupancy
//   pop_cnt           entries to retire; above PEEK_DEPTH it is treated as PEEK_DEPTH,
//                     then it is clamped to occupancy
//   pop_err           registered pulse: pop_cnt exceeded occupancy in the previous cycle
//   occupancy, empty, full, almost_full   status derived from the pointers
//
// Optional feature (macro CIRCULAR_PEEK_FIFO_STATS_EN)
//   ovf_cnt  saturating count of cycles with wr_valid && !wr_ready
//   udf_cnt  saturating count of cycles with pop_cnt > occupancy
module circular_peek_fifo #(
   parameter int DATA_WIDTH   = 512,
   parameter int BUFFER_SIZE  = 16,
   parameter int PEEK_DEPTH   = 4,
   parameter int AFULL_THRESH = 12,
   parameter int CNT_WIDTH    = 16,
   localparam int DEPTH = (BUFFER_SIZE <= 2) ? 2 : (1 << $clog2(BUFFER_SIZE)),
   localparam int AW    = $clog2(DEPTH),
   localparam int PW    = $clog2(PEEK_DEPTH + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_valid,
   input  logic [DATA_WIDTH-1:0]          wr_data,
   output logic                           wr_ready,
   output logic [PEEK_DEPTH*DATA_WIDTH-1:0] rd_data,
   output logic [PEEK_DEPTH-1:0]          rd_valid,
   input  logic [PW-1:0]                  pop_cnt,
   output logic                           pop_err,
   output logic [AW:0]                    occupancy,
   output logic                           empty,
   output logic                           full,
   output logic                           almost_full
`ifdef CIRCULAR_PEEK_FIFO_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]           ovf_cnt,
   output logic [CNT_WIDTH-1:0]           udf_cnt
`endif
);

   localparam int CW = AW + 1;
   localparam logic [PW-1:0] PEEK_MAX = PW'(PEEK_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  pop_err_q, pop_err_d;

   logic [CW-1:0]         occ;
   logic                  wr_acc;
   logic [PW-1:0]         pop_sat;
   logic [CW-1:0]         pop_ext;
   logic [CW-1:0]         eff;

   // The subtraction wraps modulo 2^CW, so occupancy stays correct across any
   // number of pointer wraps.
   assign occ         = wr_ptr_q - rd_ptr_q;
   assign occupancy   = occ;
   assign full        = occ[AW];
   assign empty       = (occ == '0);
   assign almost_full = (32'(occ) >= 32'(AFULL_THRESH));
   assign wr_ready    = !full;
   assign pop_err     = pop_err_q;

   always_comb begin
      wr_acc    = wr_valid && !full;
      pop_sat   = (pop_cnt > PEEK_MAX) ? PEEK_MAX : pop_cnt;
      pop_ext   = CW'(pop_sat);
      eff       = (pop_ext > occ) ? occ : pop_ext;
      // The error flag compares the raw request, before saturation, against occupancy.
      pop_err_d = (CW'(pop_cnt) > occ);
      wr_ptr_d  = wr_ptr_q + CW'(wr_acc);
      rd_ptr_d  = rd_ptr_q + eff;
   end

   // Peek window. The storage index is AW bits wide, so rd_ptr+k wraps at DEPTH
   // without extra logic. Slots beyond occupancy are forced to zero.
   always_comb begin
      rd_data  = '0;
      rd_valid = '0;
      for (int k = 0; k < PEEK_DEPTH; k++) begin
         if (CW'(k) < occ) begin
            rd_valid[k] = 1'b1;
            rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q[AW-1:0] + AW'(k)];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         pop_err_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         pop_err_q <= pop_err_d;
      end
   end

   // Storage is not reset. Entries outside the valid window are never exposed.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

`ifdef CIRCULAR_PEEK_FIFO_STATS_EN
   logic [CNT_WIDTH-1:0] ovf_cnt_q, udf_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_cnt_q <= '0;
         udf_cnt_q <= '0;
      end else begin
         if (wr_valid && !wr_ready && (ovf_cnt_q != '1)) begin
            ovf_cnt_q <= ovf_cnt_q + CNT_WIDTH'(1);
         end
         if (pop_err_d && (udf_cnt_q != '1)) begin
            udf_cnt_q <= udf_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   assign ovf_cnt = ovf_cnt_q;
   assign udf_cnt = udf_cnt_q;
`endif

endmodule

// File: tb/tb_circular_peek_fifo.sv
// Directed bench for circular_peek_fifo.
// Configuration: DATA_WIDTH=8, BUFFER_SIZE=10 (so DEPTH=16), PEEK_DEPTH=4, AFULL_THRESH=12.
module tb_circular_peek_fifo;

   localparam int DW = 8;
   localparam int PD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic [PD*DW-1:0] rd_data;
   logic [PD-1:0] rd_valid;
   logic [2:0]    pop_cnt;
   logic          pop_err;
   logic [4:0]    occupancy;
   logic          empty, full, almost_full;
`ifdef CIRCULAR_PEEK_FIFO_STATS_EN
   logic [15:0]   ovf_cnt, udf_cnt;
`endif

   int compared = 0;
   int mismatched = 0;

   circular_peek_fifo #(
      .DATA_WIDTH(DW), .BUFFER_SIZE(10), .PEEK_DEPTH(PD),
      .AFULL_THRESH(12), .CNT_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
      .pop_cnt(pop_cnt), .pop_err(pop_err), .occupancy(occupancy),
      .empty(empty), .full(full), .almost_full(almost_full)
`ifdef CIRCULAR_PEEK_FIFO_STATS_EN
      , .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_data = '0; pop_cnt = '0;
      step(); step();
      rst = 1'b0;

      // State after reset.
      check("rst_occ", 64'(occupancy), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full", 64'(full), 64'd0);
      check("rst_afull", 64'(almost_full), 64'd0);
      check("rst_wr_ready", 64'(wr_ready), 64'd1);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_data", 64'(rd_data), 64'd0);
      check("rst_pop_err", 64'(pop_err), 64'd0);

      // Fill with 0..15 while pop_cnt stays 0.
      for (int i = 0; i < 16; i++) begin
         wr_valid = 1'b1; wr_data = DW'(i);
         step();
         check("fill_occ", 64'(occupancy), 64'(i + 1));
         check("fill_afull", 64'(almost_full), (i + 1 >= 12) ? 64'd1 : 64'd0);
      end
      check("full_flag", 64'(full), 64'd1);
      check("full_wr_ready", 64'(wr_ready), 64'd0);
      check("full_win", 64'(rd_data), 64'h03020100);

      // A 17th write while full is held off; the FIFO contents do not change.
      wr_data = 8'hAA;
      step();
      check("hold_occ", 64'(occupancy), 64'd16);
      check("hold_win", 64'(rd_data), 64'h03020100);
`ifdef CIRCULAR_PEEK_FIFO_STATS_EN
      check("hold_ovf", 64'(ovf_cnt), 64'd1);
`endif

      // Pop 3 entries from full.
      wr_valid = 1'b0; pop_cnt = 3'd3;
      step();
      check("pop3_occ", 64'(occupancy), 64'd13);
      check("pop3_win", 64'(rd_data), 64'h06050403);
      check("pop3_valid", 64'(rd_valid), 64'hF);
      check("pop3_afull", 64'(almost_full), 64'd1);
      check("pop3_err", 64'(pop_err), 64'd0);

      // Pop 4, then 4, then 3: occupancy goes 13 -> 9 -> 5 -> 2, leaving entries 14 and 15.
      pop_cnt = 3'd4; step(); step();
      pop_cnt = 3'd3; step();
      check("two_occ", 64'(occupancy), 64'd2);
      check("two_win", 64'(rd_data), 64'h00000F0E);
      check("two_valid", 64'(rd_valid), 64'h3);

      // Pop 4 with only 2 present: the pop is clamped and pop_err pulses.
      pop_cnt = 3'd4;
      step();
      pop_cnt = 3'd0;
      check("over_occ", 64'(occupancy), 64'd0);
      check("over_empty", 64'(empty), 64'd1);
      check("over_err", 64'(pop_err), 64'd1);
      check("over_valid", 64'(rd_valid), 64'd0);
      check("over_data", 64'(rd_data), 64'd0);
`ifdef CIRCULAR_PEEK_FIFO_STATS_EN
      check("over_udf", 64'(udf_cnt), 64'd1);
`endif
      step();
      check("err_pulse", 64'(pop_err), 64'd0);

      // Write one entry, then write and pop in the same cycle.
      wr_valid = 1'b1; wr_data = 8'hC1;
      step();
      check("c1_occ", 64'(occupancy), 64'd1);
      check("c1_win", 64'(rd_data), 64'h000000C1);
      wr_data = 8'hC2; pop_cnt = 3'd1;
      step();
      check("c2_occ", 64'(occupancy), 64'd1);
      check("c2_win", 64'(rd_data), 64'h000000C2);
      check("c2_valid", 64'(rd_valid), 64'h1);
      check("c2_err", 64'(pop_err), 64'd0);

      // Streaming: one write and one pop per cycle across several pointer wraps.
      for (int i = 0; i < 100; i++) begin
         wr_data = DW'(i + 16);
         step();
         check("strm_occ", 64'(occupancy), 64'd1);
         check("strm_slot0", 64'(rd_data[DW-1:0]), 64'(DW'(i + 16)));
         check("strm_flags", 64'({full, empty}), 64'd0);
      end

      // Bring occupancy to 9.
      pop_cnt = 3'd0;
      for (int i = 0; i < 8; i++) begin
         wr_data = DW'(8'hE0 + i);
         step();
      end
      check("nine_occ", 64'(occupancy), 64'd9);

      // Reset mid-operation while a write and a pop are also requested.
      rst = 1'b1; wr_data = 8'h55; pop_cnt = 3'd2;
      step();
      rst = 1'b0; wr_valid = 1'b0; pop_cnt = 3'd0;
      check("mrst_occ", 64'(occupancy), 64'd0);
      check("mrst_empty", 64'(empty), 64'd1);
      check("mrst_ready", 64'(wr_ready), 64'd1);
      check("mrst_valid", 64'(rd_valid), 64'd0);
      check("mrst_data", 64'(rd_data), 64'd0);
`ifdef CIRCULAR_PEEK_FIFO_STATS_EN
      check("mrst_ovf", 64'(ovf_cnt), 64'd0);
      check("mrst_udf", 64'(udf_cnt), 64'd0);
`endif
      step();
      check("mrst_drop", 64'(occupancy), 64'd0);

      // pop_cnt=7 is above PEEK_DEPTH, so it retires 4 entries. It still flags an
      // error because 7 > 6.
      wr_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_data = DW'(8'hD0 + i);
         step();
      end
      wr_valid = 1'b0; pop_cnt = 3'd7;
      step();
      pop_cnt = 3'd0;
      check("sat_occ", 64'(occupancy), 64'd2);
      check("sat_win", 64'(rd_data), 64'h0000D5D4);
      check("sat_err", 64'(pop_err), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
